// File: rtl/dmem_responder_if.sv
// Load/store bus between the RV32I control unit and the data memory.
// AXI-lite-style AW/W/B and AR/R channels with per-transfer error flags.
interface dmem_responder_if;
  logic [31:0] DMEM_AWADDR;
  logic        DMEM_AWVALID;
  logic        DMEM_AWREADY;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_WSTRB;
  logic        DMEM_WVALID;
  logic        DMEM_WREADY;
  logic        DMEM_BVALID;
  logic        DMEM_BREADY;
  logic        DMEM_BERR;
  logic [31:0] DMEM_ARADDR;
  logic        DMEM_ARVALID;
  logic        DMEM_ARREADY;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_RVALID;
  logic        DMEM_RREADY;
  logic        DMEM_RERR;

  modport master (
    output DMEM_AWADDR, DMEM_AWVALID, DMEM_WDATA, DMEM_WSTRB, DMEM_WVALID,
           DMEM_BREADY, DMEM_ARADDR, DMEM_ARVALID, DMEM_RREADY,
    input  DMEM_AWREADY, DMEM_WREADY, DMEM_BVALID, DMEM_BERR,
           DMEM_ARREADY, DMEM_RDATA, DMEM_RVALID, DMEM_RERR
  );

  modport slave (
    input  DMEM_AWADDR, DMEM_AWVALID, DMEM_WDATA, DMEM_WSTRB, DMEM_WVALID,
           DMEM_BREADY, DMEM_ARADDR, DMEM_ARVALID, DMEM_RREADY,
    output DMEM_AWREADY, DMEM_WREADY, DMEM_BVALID, DMEM_BERR,
           DMEM_ARREADY, DMEM_RDATA, DMEM_RVALID, DMEM_RERR
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte strobes, wait states,
// address range checking and an internal word-organised RAM.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int          IDXW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] SPAN    = 34'(DEPTH_WORDS) * 34'd4;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_RD_WAIT,
    S_WR_RESP,
    S_RD_RESP
  } state_t;

  function automatic logic fInRange(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({2'b00, off} < SPAN);
  endfunction

  function automatic logic [IDXW-1:0] fIndex(input logic [31:0] a);
    return IDXW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0]     r_mem [DEPTH_WORDS];

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [IDXW-1:0] r_idx;
  logic            r_inRange;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic            r_bvalid;
  logic            r_berr;
  logic            r_rvalid;
  logic            r_rerr;
  logic [31:0]     r_rdata;

  logic            w_wrReq;
  logic            w_wrAccept;
  logic            w_rdAccept;
  logic            w_wrCommit;
  logic            w_rdFill;
  logic [IDXW-1:0] w_wrIdx;
  logic            w_wrInRange;
  logic [31:0]     w_wrData;
  logic [3:0]      w_wrStrb;
  logic [IDXW-1:0] w_rdIdx;
  logic            w_rdInRange;
  logic [31:0]     w_rdWord;

  // A write needs AW and W together and always beats a simultaneous read.
  assign w_wrReq    = bus.DMEM_AWVALID & bus.DMEM_WVALID;
  assign w_wrAccept = (r_state == S_IDLE) & w_wrReq;
  assign w_rdAccept = (r_state == S_IDLE) & bus.DMEM_ARVALID & ~w_wrReq;

  // With zero wait states the RAM access happens on the accepting edge, so
  // it must use the live bus fields instead of the latched copies.
  assign w_wrCommit  = (NO_WAIT & w_wrAccept) | ((r_state == S_WR_WAIT) & (r_cnt == 4'd1));
  assign w_rdFill    = (NO_WAIT & w_rdAccept) | ((r_state == S_RD_WAIT) & (r_cnt == 4'd1));
  assign w_wrIdx     = NO_WAIT ? fIndex(bus.DMEM_AWADDR)   : r_idx;
  assign w_wrInRange = NO_WAIT ? fInRange(bus.DMEM_AWADDR) : r_inRange;
  assign w_wrData    = NO_WAIT ? bus.DMEM_WDATA            : r_wdata;
  assign w_wrStrb    = NO_WAIT ? bus.DMEM_WSTRB            : r_wstrb;
  assign w_rdIdx     = NO_WAIT ? fIndex(bus.DMEM_ARADDR)   : r_idx;
  assign w_rdInRange = NO_WAIT ? fInRange(bus.DMEM_ARADDR) : r_inRange;
  assign w_rdWord    = w_rdInRange ? r_mem[w_rdIdx] : 32'h0;

  assign bus.DMEM_AWREADY = w_wrAccept;
  assign bus.DMEM_WREADY  = w_wrAccept;
  assign bus.DMEM_ARREADY = w_rdAccept;
  assign bus.DMEM_BVALID  = r_bvalid;
  assign bus.DMEM_BERR    = r_berr;
  assign bus.DMEM_RVALID  = r_rvalid;
  assign bus.DMEM_RERR    = r_rerr;
  assign bus.DMEM_RDATA   = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_inRange <= 1'b0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_bvalid  <= 1'b0;
      r_berr    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rerr    <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wrAccept) begin
            r_idx     <= fIndex(bus.DMEM_AWADDR);
            r_inRange <= fInRange(bus.DMEM_AWADDR);
            r_wdata   <= bus.DMEM_WDATA;
            r_wstrb   <= bus.DMEM_WSTRB;
            r_cnt     <= WAIT_LD;
            if (NO_WAIT) begin
              r_state  <= S_WR_RESP;
              r_bvalid <= 1'b1;
              r_berr   <= ~w_wrInRange;
            end else begin
              r_state  <= S_WR_WAIT;
            end
          end else if (w_rdAccept) begin
            r_idx     <= fIndex(bus.DMEM_ARADDR);
            r_inRange <= fInRange(bus.DMEM_ARADDR);
            r_cnt     <= WAIT_LD;
            if (NO_WAIT) begin
              r_state  <= S_RD_RESP;
              r_rvalid <= 1'b1;
              r_rerr   <= ~w_rdInRange;
              r_rdata  <= w_rdWord;
            end else begin
              r_state  <= S_RD_WAIT;
            end
          end
        end
        S_WR_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_wrCommit) begin
            r_state  <= S_WR_RESP;
            r_bvalid <= 1'b1;
            r_berr   <= ~r_inRange;
          end
        end
        S_RD_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_rdFill) begin
            r_state  <= S_RD_RESP;
            r_rvalid <= 1'b1;
            r_rerr   <= ~r_inRange;
            r_rdata  <= w_rdWord;
          end
        end
        S_WR_RESP: begin
          if (bus.DMEM_BREADY) begin
            r_state  <= S_IDLE;
            r_bvalid <= 1'b0;
            r_berr   <= 1'b0;
          end
        end
        S_RD_RESP: begin
          if (bus.DMEM_RREADY) begin
            r_state  <= S_IDLE;
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wrCommit && w_wrInRange) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wrStrb[b]) r_mem[w_wrIdx][8*b +: 8] <= w_wrData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state and one
// with three; both see the same stimulus and sel picks whose outputs are read.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst3 = 1'b1;
  logic        sel = 1'b0;

  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b1;

  logic        awready, wready, bvalid, berr, arready, rvalid, rerr;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus1 ();
  dmem_responder_if bus3 ();

  assign bus1.DMEM_AWADDR  = awaddr;
  assign bus1.DMEM_AWVALID = awvalid;
  assign bus1.DMEM_WDATA   = wdata;
  assign bus1.DMEM_WSTRB   = wstrb;
  assign bus1.DMEM_WVALID  = wvalid;
  assign bus1.DMEM_BREADY  = bready;
  assign bus1.DMEM_ARADDR  = araddr;
  assign bus1.DMEM_ARVALID = arvalid;
  assign bus1.DMEM_RREADY  = rready;

  assign bus3.DMEM_AWADDR  = awaddr;
  assign bus3.DMEM_AWVALID = awvalid;
  assign bus3.DMEM_WDATA   = wdata;
  assign bus3.DMEM_WSTRB   = wstrb;
  assign bus3.DMEM_WVALID  = wvalid;
  assign bus3.DMEM_BREADY  = bready;
  assign bus3.DMEM_ARADDR  = araddr;
  assign bus3.DMEM_ARVALID = arvalid;
  assign bus3.DMEM_RREADY  = rready;

  assign awready = sel ? bus3.DMEM_AWREADY : bus1.DMEM_AWREADY;
  assign wready  = sel ? bus3.DMEM_WREADY  : bus1.DMEM_WREADY;
  assign bvalid  = sel ? bus3.DMEM_BVALID  : bus1.DMEM_BVALID;
  assign berr    = sel ? bus3.DMEM_BERR    : bus1.DMEM_BERR;
  assign arready = sel ? bus3.DMEM_ARREADY : bus1.DMEM_ARREADY;
  assign rvalid  = sel ? bus3.DMEM_RVALID  : bus1.DMEM_RVALID;
  assign rerr    = sel ? bus3.DMEM_RERR    : bus1.DMEM_RERR;
  assign rdata   = sel ? bus3.DMEM_RDATA   : bus1.DMEM_RDATA;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  // Drives one write; lat counts cycles from acceptance to BVALID, -1 if never accepted.
  task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int lat, output logic err, output logic after);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!(awready && wready)) begin
      awvalid = 1'b0; wvalid = 1'b0;
      lat = -1; err = 1'bx; after = 1'bx;
      return;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    lat = 1;
    while (!bvalid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    err = berr;
    @(negedge clk); #1;
    after = bvalid;
  endtask

  task automatic doRead(input logic [31:0] a, output int lat, output logic [31:0] d,
                        output logic err);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!arready) begin
      arvalid = 1'b0;
      lat = -1; d = 'x; err = 1'bx;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    lat = 1;
    while (!rvalid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    d = rdata;
    err = rerr;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++; if (bvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bvalid dut%0d got=%b want=0", s, bvalid); end
      checks++; if (berr !== 1'b0) begin errors++; $display("[TB] FAIL reset_berr dut%0d got=%b want=0", s, berr); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid dut%0d got=%b want=0", s, rvalid); end
      checks++; if (rerr !== 1'b0) begin errors++; $display("[TB] FAIL reset_rerr dut%0d got=%b want=0", s, rerr); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata dut%0d got=%h want=0", s, rdata); end
    end
    sel = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic err, after; logic [31:0] d;
    doWrite(32'h10, 32'hDEADBEEF, 4'hF, lat, err, after);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL basic_wr_latency got=%0d want=2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_berr got=%b want=0", err); end
    checks++; if (after !== 1'b0) begin errors++; $display("[TB] FAIL basic_bvalid_drop got=%b want=0", after); end
    doRead(32'h10, lat, d, err);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL basic_rd_latency got=%0d want=2", lat); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL basic_rdata got=%h want=deadbeef", d); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_rerr got=%b want=0", err); end
    doRead(32'h13, lat, d, err);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL unaligned_rdata got=%h want=deadbeef", d); end
  endtask

  task automatic test_byte_strobe();
    int lat; logic err, after; logic [31:0] d;
    doWrite(32'h20, 32'h11223344, 4'hF, lat, err, after);
    doWrite(32'h20, 32'hAABBCCDD, 4'b0101, lat, err, after);
    doRead(32'h20, lat, d, err);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL strobe_0101 got=%h want=11bb33dd", d); end
    doWrite(32'h20, 32'h00000000, 4'b0000, lat, err, after);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL strobe_zero_latency got=%0d want=2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL strobe_zero_berr got=%b want=0", err); end
    doRead(32'h20, lat, d, err);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL strobe_zero_data got=%h want=11bb33dd", d); end
    doWrite(32'h24, 32'hFFFFFFFF, 4'hF, lat, err, after);
    doWrite(32'h24, 32'h12345678, 4'b1010, lat, err, after);
    doRead(32'h24, lat, d, err);
    checks++; if (d !== 32'h12FF56FF) begin errors++; $display("[TB] FAIL strobe_1010 got=%h want=12ff56ff", d); end
  endtask

  task automatic test_contention();
    int n, lat;
    @(negedge clk);
    awaddr = 32'h30; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h30; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    #1;
    checks++; if (awready !== 1'b1) begin errors++; $display("[TB] FAIL contend_awready got=%b want=1", awready); end
    checks++; if (arready !== 1'b0) begin errors++; $display("[TB] FAIL contend_arready got=%b want=0", arready); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++; if (n !== 2) begin errors++; $display("[TB] FAIL contend_read_wait got=%0d want=2", n); end
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    lat = 1;
    while (!rvalid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL contend_rd_latency got=%0d want=2", lat); end
    checks++; if (rdata !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL contend_rdata got=%h want=5a5a5a5a", rdata); end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int lat; logic err, after; logic [31:0] d;
    doWrite(32'h0, 32'hCAFEF00D, 4'hF, lat, err, after);
    doWrite(32'h1000, 32'hFFFFFFFF, 4'hF, lat, err, after);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL oor_berr got=%b want=1", err); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL oor_wr_latency got=%0d want=2", lat); end
    doRead(32'h1000, lat, d, err);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL oor_rerr got=%b want=1", err); end
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL oor_rdata got=%h want=0", d); end
    doRead(32'h0, lat, d, err);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL oor_word0 got=%h want=cafef00d", d); end
    doWrite(32'hFFC, 32'h01020304, 4'hF, lat, err, after);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL top_word_berr got=%b want=0", err); end
    doRead(32'hFFC, lat, d, err);
    checks++; if (d !== 32'h01020304) begin errors++; $display("[TB] FAIL top_word_rdata got=%h want=01020304", d); end
  endtask

  task automatic test_back_pressure();
    int n, lat; logic err, after;
    doWrite(32'h50, 32'h600DF00D, 4'hF, lat, err, after);
    @(negedge clk);
    araddr = 32'h50; arvalid = 1'b1; rready = 1'b0;
    #1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    lat = 1;
    while (!rvalid && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL bp_rd_latency got=%0d want=2", lat); end
    for (int i = 0; i < 5; i++) begin
      araddr = 32'h10; arvalid = 1'b1;
      #1;
      checks++; if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_rvalid cyc%0d got=%b want=1", i, rvalid); end
      checks++; if (rdata !== 32'h600DF00D) begin errors++; $display("[TB] FAIL bp_rdata cyc%0d got=%h want=600df00d", i, rdata); end
      checks++; if (arready !== 1'b0) begin errors++; $display("[TB] FAIL bp_arready cyc%0d got=%b want=0", i, arready); end
      @(negedge clk);
    end
    rready = 1'b1; arvalid = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_complete_cycle got=%b want=1", rvalid); end
    @(negedge clk); #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_rvalid_drop got=%b want=0", rvalid); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic err, after; logic [31:0] d;
    sel = 1'b1;
    @(negedge clk); rst3 = 1'b1;
    @(negedge clk); rst3 = 1'b0;
    doWrite(32'h40, 32'h00000000, 4'hF, lat, err, after);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL w3_wr_latency got=%0d want=4", lat); end
    doWrite(32'h44, 32'h0BADCAFE, 4'hF, lat, err, after);
    doRead(32'h44, lat, d, err);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL w3_rd_latency got=%0d want=4", lat); end
    checks++; if (d !== 32'h0BADCAFE) begin errors++; $display("[TB] FAIL w3_rdata got=%h want=0badcafe", d); end
    @(negedge clk);
    awaddr = 32'h40; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    checks++; if (awready !== 1'b1) begin errors++; $display("[TB] FAIL w3_accept got=%b want=1", awready); end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0BADCAFE) begin errors++; $display("[TB] FAIL w3_rdata_held got=%h want=0badcafe", rdata); end
    rst3 = 1'b1;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL w3_async_rdata got=%h want=0", rdata); end
    checks++; if ({bvalid, berr, rvalid, rerr} !== 4'b0000) begin errors++; $display("[TB] FAIL w3_async_flags got=%b want=0000", {bvalid, berr, rvalid, rerr}); end
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    repeat (5) @(negedge clk);
    doRead(32'h40, lat, d, err);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL w3_discarded_write got=%h want=0", d); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL w3_rerr got=%b want=0", err); end
    sel = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    test_basic();
    test_byte_strobe();
    test_contention();
    test_out_of_range();
    test_back_pressure();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
